// File: rtl/myproject_arith_pkg.sv
// rtl/myproject_arith_pkg.sv - shared arithmetic types and constants for the sdiv/mul blocks
//
// Purpose: state enum of the sequential signed divider, saturation limit
//          helpers and the layer widths shared with the mul_16s_9s_23 blocks.
// Ports:   none (package).
package myproject_arith_pkg;

    // Widths of the 16s x 9s -> 23 multiplier that the divider inverts.
    localparam int MUL_DIN0_WIDTH = 16;
    localparam int MUL_DIN1_WIDTH = 9;
    localparam int MUL_DOUT_WIDTH = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sdiv_state_e;

    // Largest value representable in a w-bit two's complement word.
    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/myproject_sdiv_step.sv
// rtl/myproject_sdiv_step.sv - one combinational radix-2 restoring division step
//
// Purpose: shift the next dividend bit into the partial remainder and subtract
//          the divisor magnitude when it fits.
// Ports:   rem_i   partial remainder in (unsigned, < dvs_i)
//          bit_i   next dividend magnitude bit, MSB first
//          dvs_i   divisor magnitude
//          rem_o   partial remainder out
//          qbit_o  quotient bit produced by this step
module myproject_sdiv_step #(
    parameter int RW = 10
) (
    input  logic [RW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [RW-1:0] dvs_i,
    output logic [RW-1:0] rem_o,
    output logic          qbit_o
);

    logic [RW:0] part;

    assign part   = {rem_i, bit_i};
    assign qbit_o = (part >= {1'b0, dvs_i});
    // When the divisor fits, the difference is below dvs_i, so RW bits
    // of modular subtraction are exact.
    assign rem_o  = qbit_o ? (part[RW-1:0] - dvs_i) : part[RW-1:0];

endmodule

// File: rtl/myproject_sdiv_23s_9s_16_seq.sv
// rtl/myproject_sdiv_23s_9s_16_seq.sv - iterative 23s / 9s -> 16s saturating signed divider
//
// Purpose: radix-2 restoring division on magnitudes, one quotient bit per
//          clock, truncation toward zero, result saturated to DOUT_WIDTH.
// Ports:   ap_clk, ap_rst_n (async, active low)
//          in_valid/in_ready/din0/din1     operand handshake
//          out_valid/out_ready/dout/ovf/dbz result handshake and flags
//          rem (only with SDIV_REM_EN)     signed remainder, sign of dividend
// Config:  SDIV_REM_EN adds the rem output and its register.
module myproject_sdiv_23s_9s_16_seq
    import myproject_arith_pkg::*;
#(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = 23,
    parameter int DIN1_WIDTH = 9,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  dbz
`ifdef SDIV_REM_EN
    ,
    output logic [DIN1_WIDTH-1:0] rem
`endif
);

    localparam int RW = DIN1_WIDTH + 1;
    localparam int QW = DIN0_WIDTH + 1;
    localparam int CW = $clog2(DIN0_WIDTH);
    localparam logic signed [QW-1:0] SAT_MAX_Q = QW'(sat_max(DOUT_WIDTH));
    localparam logic signed [QW-1:0] SAT_MIN_Q = QW'(sat_min(DOUT_WIDTH));

    sdiv_state_e state_q, state_d;

    logic [DIN0_WIDTH-1:0] dq_q;    // dividend magnitude shifting out, quotient shifting in
    logic [RW-1:0]         rem_q;
    logic [RW-1:0]         dvs_q;
    logic [CW-1:0]         cnt_q;
    logic                  sq_q, s0_q, dz_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  ovf_q, dbz_q;

    logic                  accept;
    logic [DIN0_WIDTH-1:0] din0_mag;
    logic [RW-1:0]         din1_mag;
    logic [RW-1:0]         rem_nxt;
    logic                  qbit;
    logic signed [QW-1:0]  q_full;
    logic [DOUT_WIDTH-1:0] dout_fix;
    logic                  ovf_fix;

    assign accept = in_valid && (state_q == IDLE);

    // Unsigned DIN0_WIDTH bits hold |-2^(DIN0_WIDTH-1)| exactly.
    assign din0_mag = din0[DIN0_WIDTH-1] ? (~din0 + 1'b1) : din0;
    assign din1_mag = {1'b0, din1[DIN1_WIDTH-1] ? (~din1 + 1'b1) : din1};

    myproject_sdiv_step #(.RW(RW)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dq_q[DIN0_WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (rem_nxt),
        .qbit_o (qbit)
    );

    assign q_full = sq_q ? -$signed({1'b0, dq_q}) : $signed({1'b0, dq_q});

    always_comb begin
        dout_fix = q_full[DOUT_WIDTH-1:0];
        ovf_fix  = 1'b0;
        if (dz_q) begin
            dout_fix = s0_q ? SAT_MIN_Q[DOUT_WIDTH-1:0] : SAT_MAX_Q[DOUT_WIDTH-1:0];
        end else if (q_full > SAT_MAX_Q) begin
            dout_fix = SAT_MAX_Q[DOUT_WIDTH-1:0];
            ovf_fix  = 1'b1;
        end else if (q_full < SAT_MIN_Q) begin
            dout_fix = SAT_MIN_Q[DOUT_WIDTH-1:0];
            ovf_fix  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (cnt_q == CW'(DIN0_WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            sq_q   <= 1'b0;
            s0_q   <= 1'b0;
            dz_q   <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            dq_q   <= din0_mag;
            rem_q  <= '0;
            dvs_q  <= din1_mag;
            cnt_q  <= '0;
            sq_q   <= din0[DIN0_WIDTH-1] ^ din1[DIN1_WIDTH-1];
            s0_q   <= din0[DIN0_WIDTH-1];
            dz_q   <= (din1 == '0);
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (state_q == CALC) begin
            dq_q   <= {dq_q[DIN0_WIDTH-2:0], qbit};
            rem_q  <= rem_nxt;
            cnt_q  <= cnt_q + 1'b1;
        end else if (state_q == FIX) begin
            dout_q <= dout_fix;
            ovf_q  <= ovf_fix;
            dbz_q  <= dz_q;
        end
    end

`ifdef SDIV_REM_EN
    logic [DIN1_WIDTH-1:0] lo_q;
    logic [DIN1_WIDTH-1:0] rem_out_q;
    logic [DIN1_WIDTH-1:0] rem_lo;

    // Remainder magnitude is below |din1| <= 2^(DIN1_WIDTH-1), so it fits.
    assign rem_lo = rem_q[DIN1_WIDTH-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lo_q      <= '0;
            rem_out_q <= '0;
        end else if (accept) begin
            lo_q      <= din0[DIN1_WIDTH-1:0];
        end else if (state_q == FIX) begin
            if (dz_q) begin
                rem_out_q <= lo_q;
            end else begin
                rem_out_q <= s0_q ? (~rem_lo + 1'b1) : rem_lo;
            end
        end
    end

    assign rem = rem_out_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dout      = dout_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
